// File: rtl/pixel_frame_sequencer.sv
// Frame controller for the digital pixel array: ERASE -> EXPOSE -> CONVERT -> READ,
// with a shared ADC ramp count and per-handshake row stepping onto the data bus.
module pixel_frame_sequencer #(
    parameter int ERASE_CYCLES = 5,
    parameter int EXPOSE_TIME  = 255,
    parameter int CNT_W        = 8,
    parameter int ROWS         = 2,
    parameter int GRAY         = 1,
    localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic             rd_ready,
    output logic             erase,
    output logic             expose,
    output logic             convert,
    output logic             read,
    output logic [ROW_W-1:0] row_sel,
    output logic [CNT_W-1:0] adc_count,
    output logic             busy,
    output logic             frame_done
);

    localparam int PH_MAX = (ERASE_CYCLES > EXPOSE_TIME) ? ERASE_CYCLES : EXPOSE_TIME;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0]  ERASE_LAST  = PH_W'(ERASE_CYCLES - 1);
    localparam logic [PH_W-1:0]  EXPOSE_LAST = PH_W'(EXPOSE_TIME - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] RAMP_LAST   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ
    } state_t;

    state_t           state;
    logic [PH_W-1:0]  ph_cnt;
    logic [CNT_W-1:0] ramp;

    function automatic logic [CNT_W-1:0] encode(input logic [CNT_W-1:0] b);
        return (GRAY != 0) ? (b ^ (b >> 1)) : b;
    endfunction

    // Every output is a flop updated on the same edge as the state change, so
    // the strobes line up exactly with the phase they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ph_cnt     <= '0;
            ramp       <= '0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            read       <= 1'b0;
            row_sel    <= '0;
            adc_count  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else if (abort) begin
            state      <= S_IDLE;
            ph_cnt     <= '0;
            ramp       <= '0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            read       <= 1'b0;
            row_sel    <= '0;
            adc_count  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; a later assignment in the same
            // branch (e.g. frame_done on the last row) overrides this default.
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_ERASE;
                        erase  <= 1'b1;
                        busy   <= 1'b1;
                        ph_cnt <= '0;
                    end
                end
                S_ERASE: begin
                    if (ph_cnt == ERASE_LAST) begin
                        state  <= S_EXPOSE;
                        erase  <= 1'b0;
                        expose <= 1'b1;
                        ph_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                S_EXPOSE: begin
                    if (ph_cnt == EXPOSE_LAST) begin
                        state     <= S_CONVERT;
                        expose    <= 1'b0;
                        convert   <= 1'b1;
                        ph_cnt    <= '0;
                        ramp      <= '0;
                        adc_count <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                S_CONVERT: begin
                    // Single ramp pass; the terminal count hands over to READ.
                    if (ramp == RAMP_LAST) begin
                        state     <= S_READ;
                        convert   <= 1'b0;
                        read      <= 1'b1;
                        row_sel   <= '0;
                        ramp      <= '0;
                        adc_count <= '0;
                    end else begin
                        ramp      <= ramp + 1'b1;
                        adc_count <= encode(ramp + 1'b1);
                    end
                end
                S_READ: begin
                    if (rd_ready) begin
                        if (row_sel == ROW_LAST) begin
                            row_sel    <= '0;
                            read       <= 1'b0;
                            frame_done <= 1'b1;
                            if (cont) begin
                                state  <= S_ERASE;
                                erase  <= 1'b1;
                                ph_cnt <= '0;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            row_sel <= row_sel + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Directed bench for pixel_frame_sequencer: binary instance checked cycle by cycle
// against a frame timeline, plus a Gray-coded twin checked during CONVERT.
module tb_pixel_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       abort = 1'b0;
    logic       rd_ready = 1'b1;

    logic       erase, expose, convert, read, busy, frame_done;
    logic [0:0] row_sel;
    logic [7:0] adc_count;

    logic       erase_g, expose_g, convert_g, read_g, busy_g, frame_done_g;
    logic [0:0] row_sel_g;
    logic [7:0] adc_g;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pixel_frame_sequencer #(
        .ERASE_CYCLES(5), .EXPOSE_TIME(255), .CNT_W(8), .ROWS(2), .GRAY(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cont(cont), .abort(abort),
        .rd_ready(rd_ready), .erase(erase), .expose(expose), .convert(convert),
        .read(read), .row_sel(row_sel), .adc_count(adc_count), .busy(busy),
        .frame_done(frame_done)
    );

    pixel_frame_sequencer #(
        .ERASE_CYCLES(5), .EXPOSE_TIME(255), .CNT_W(8), .ROWS(2), .GRAY(1)
    ) dut_gray (
        .clk(clk), .reset(reset), .start(start), .cont(cont), .abort(abort),
        .rd_ready(rd_ready), .erase(erase_g), .expose(expose_g), .convert(convert_g),
        .read(read_g), .row_sel(row_sel_g), .adc_count(adc_g), .busy(busy_g),
        .frame_done(frame_done_g)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] obs_vec();
        return {busy, erase, expose, convert, read, frame_done, row_sel, adc_count};
    endfunction

    // Expected outputs c cycles after the start edge (c >= 1); a stall holds row 0.
    function automatic logic [14:0] model(input int c, input int stall, input logic fd);
        logic       e_busy, e_erase, e_expose, e_convert, e_read;
        logic [0:0] e_row;
        logic [7:0] e_adc;
        e_busy = 1'b1; e_erase = 1'b0; e_expose = 1'b0; e_convert = 1'b0;
        e_read = 1'b0; e_row = 1'b0; e_adc = 8'd0;
        if (c <= 5)                 e_erase = 1'b1;
        else if (c <= 260)          e_expose = 1'b1;
        else if (c <= 516) begin
            e_convert = 1'b1;
            e_adc     = 8'(c - 261);
        end else if (c <= 517 + stall) e_read = 1'b1;
        else if (c == 518 + stall) begin
            e_read = 1'b1;
            e_row  = 1'b1;
        end else                    e_busy = 1'b0;
        return {e_busy, e_erase, e_expose, e_convert, e_read, fd, e_row, e_adc};
    endfunction

    // Runs one frame from cycle 1 (start edge already taken). fd1 expects the
    // previous frame's done pulse on cycle 1 (continuous mode).
    task automatic run_frame(input int stall, input logic cont_v, input logic fd1, input string name);
        logic [7:0] prev_g;
        logic [7:0] bin;
        prev_g = 8'd0;
        cont   = cont_v;
        for (int c = 1; c <= 518 + stall; c++) begin
            rd_ready = !(c >= 517 && c < 517 + stall);
            start    = (c == 50);
            check($sformatf("%s c%0d", name, c), 32'(obs_vec()), 32'(model(c, stall, (c == 1) && fd1)));
            if (c >= 261 && c <= 516) begin
                bin = 8'(c - 261);
                check($sformatf("%s gray c%0d", name, c), 32'(adc_g), 32'(bin ^ (bin >> 1)));
                if (c > 261)
                    check($sformatf("%s gray_step c%0d", name, c), 32'($countones(adc_g ^ prev_g)), 32'd1);
                prev_g = adc_g;
            end
            step();
        end
        start    = 1'b0;
        rd_ready = 1'b1;
        if (!cont_v) begin
            check($sformatf("%s done", name), 32'(obs_vec()), 32'(model(519 + stall, stall, 1'b1)));
            step();
            check($sformatf("%s idle", name), 32'(obs_vec()), 32'(model(520 + stall, stall, 1'b0)));
        end
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        check("reset_state", 32'(obs_vec()), 32'd0);
        check("reset_state_gray", 32'(adc_g), 32'd0);
        reset = 1'b1;
        step();
        check("idle_after_reset", 32'(obs_vec()), 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_in_idle", 32'(obs_vec()), 32'd0);

        kick();
        run_frame(0, 1'b0, 1'b0, "single");

        kick();
        run_frame(10, 1'b0, 1'b0, "stall");

        kick();
        run_frame(0, 1'b1, 1'b0, "cont1");
        run_frame(0, 1'b1, 1'b1, "cont2");
        run_frame(0, 1'b0, 1'b1, "cont3");

        kick();
        for (int c = 1; c <= 100; c++) begin
            check($sformatf("pre_abort c%0d", c), 32'(obs_vec()), 32'(model(c, 0, 1'b0)));
            if (c == 100) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        for (int c = 101; c <= 104; c++) begin
            check($sformatf("aborted c%0d", c), 32'(obs_vec()), 32'd0);
            step();
        end
        kick();
        run_frame(0, 1'b0, 1'b0, "after_abort");

        kick();
        for (int c = 1; c < 325; c++) step();
        check("adc_at_0x40", 32'(adc_count), 32'h40);
        check("convert_at_0x40", 32'(convert), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 32'(obs_vec()), 32'd0);
        check("async_reset_gray", 32'(adc_g), 32'd0);
        repeat (2) step();
        reset = 1'b1;
        step();
        check("idle_after_reset2", 32'(obs_vec()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
